// File: rtl/axi_stream_strip_header.sv
// axi_stream_strip_header
//
// Removes a per-packet number of leading bytes from the first beat of an
// AXI-Stream packet and realigns the remainder into MSB-first beats on a
// single registered output stage.
//
// Ports:
//   clk, rst_n                   clock, asynchronous active-low reset
//   valid_in/ready_in            upstream beat handshake
//   data_in/keep_in/last_in      upstream beat (byte 0 in the top byte lane)
//   valid_out/ready_out          downstream beat handshake
//   data_out/keep_out/last_out   realigned beat; unkept bytes are zero
//   valid_strip/ready_strip      per-packet strip count handshake
//   byte_strip_cnt               leading bytes to remove (0..N-1)
//
// Optional feature, macro STRIP_HDR_OUT_EN:
//   hdr_valid/hdr_data/hdr_keep  stripped bytes, right-justified, with a
//                                one-cycle valid pulse after the first beat
//
// Requires DATA_BYTE_WD >= 2.
module axi_stream_strip_header #(
    parameter int DATA_WD      = 32,
    parameter int DATA_BYTE_WD = DATA_WD / 8,
    parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    valid_in,
    output logic                    ready_in,
    input  logic [DATA_WD-1:0]      data_in,
    input  logic [DATA_BYTE_WD-1:0] keep_in,
    input  logic                    last_in,
    output logic                    valid_out,
    input  logic                    ready_out,
    output logic [DATA_WD-1:0]      data_out,
    output logic [DATA_BYTE_WD-1:0] keep_out,
    output logic                    last_out,
    input  logic                    valid_strip,
    output logic                    ready_strip,
    input  logic [BYTE_CNT_WD-1:0]  byte_strip_cnt
`ifdef STRIP_HDR_OUT_EN
    ,
    output logic                    hdr_valid,
    output logic [DATA_WD-1:0]      hdr_data,
    output logic [DATA_BYTE_WD-1:0] hdr_keep
`endif
);

    localparam int N  = DATA_BYTE_WD;
    // Byte counts up to 2N must fit (residual + incoming valid bytes).
    localparam int CW = BYTE_CNT_WD + 2;

    typedef logic [CW-1:0] cnt_t;

    typedef enum logic [1:0] {
        IDLE,
        FIRST,
        RUN,
        FLUSH
    } state_t;

    // Keep mask with the k most significant lanes set.
    function automatic logic [N-1:0] msb_keep(input cnt_t k);
        logic [N-1:0] m;
        m = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (cnt_t'(i) < k) m[N-1-i] = 1'b1;
        end
        return m;
    endfunction

    // Keep mask with the k least significant lanes set.
    function automatic logic [N-1:0] lsb_keep(input cnt_t k);
        logic [N-1:0] m;
        m = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (cnt_t'(i) < k) m[i] = 1'b1;
        end
        return m;
    endfunction

    function automatic logic [DATA_WD-1:0] byte_mask(input logic [N-1:0] k);
        logic [DATA_WD-1:0] m;
        for (int unsigned i = 0; i < N; i++) begin
            m[8*i +: 8] = {8{k[i]}};
        end
        return m;
    endfunction

    function automatic cnt_t popcount(input logic [N-1:0] k);
        cnt_t c;
        c = '0;
        for (int unsigned i = 0; i < N; i++) begin
            c = c + cnt_t'(k[i]);
        end
        return c;
    endfunction

    state_t                 state_q;
    logic [BYTE_CNT_WD-1:0] cnt_q;
    logic [DATA_WD-1:0]     res_q;
    cnt_t                   res_cnt_q;
    logic                   valid_out_q;
    logic [DATA_WD-1:0]     data_out_q;
    logic [N-1:0]           keep_out_q;
    logic                   last_out_q;
    logic                   ready_strip_q;
`ifdef STRIP_HDR_OUT_EN
    logic                   hdr_valid_q;
    logic [DATA_WD-1:0]     hdr_data_q;
    logic [N-1:0]           hdr_keep_q;
`endif

    logic                   out_free;
    logic                   in_fire;
    logic                   strip_fire;
    cnt_t                   cnt_ext;
    cnt_t                   v;
    cnt_t                   res_total;
    logic [DATA_WD-1:0]     data_m;
    logic [DATA_WD-1:0]     first_shift;
    logic [2*DATA_WD-1:0]   merged;

    assign out_free   = !valid_out_q || ready_out;
    assign ready_in   = ((state_q == FIRST) || (state_q == RUN)) && out_free;
    assign in_fire    = valid_in && ready_in;
    assign strip_fire = valid_strip && ready_strip_q;

    always_comb begin
        cnt_ext     = cnt_t'(cnt_q);
        // Only the popcount of keep_in matters; lanes beyond it are zeroed
        // so they can never leak into kept output bytes.
        v           = last_in ? popcount(keep_in) : cnt_t'(N);
        data_m      = data_in & byte_mask(msb_keep(v));
        first_shift = data_m << {cnt_ext, 3'b000};
        res_total   = res_cnt_q + v;
        // Upper half: residual followed by the head of the beat (one output
        // beat). Lower half: the beat's leftover bytes, MSB-aligned.
        merged      = {res_q, {DATA_WD{1'b0}}}
                    | ({{DATA_WD{1'b0}}, data_m} << {cnt_t'(N) - res_cnt_q, 3'b000});
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            res_q         <= '0;
            res_cnt_q     <= '0;
            valid_out_q   <= 1'b0;
            data_out_q    <= '0;
            keep_out_q    <= '0;
            last_out_q    <= 1'b0;
            ready_strip_q <= 1'b0;
`ifdef STRIP_HDR_OUT_EN
            hdr_valid_q   <= 1'b0;
            hdr_data_q    <= '0;
            hdr_keep_q    <= '0;
`endif
        end else begin
            // Slot drains by default; any load below overrides this.
            if (out_free) valid_out_q <= 1'b0;
`ifdef STRIP_HDR_OUT_EN
            hdr_valid_q <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    ready_strip_q <= 1'b1;
                    if (strip_fire) begin
                        cnt_q         <= byte_strip_cnt;
                        ready_strip_q <= 1'b0;
                        state_q       <= FIRST;
                    end
                end
                FIRST: begin
                    if (in_fire) begin
`ifdef STRIP_HDR_OUT_EN
                        if (cnt_q != '0) begin
                            hdr_valid_q <= 1'b1;
                            hdr_data_q  <= data_m >> {cnt_t'(N) - cnt_ext, 3'b000};
                            hdr_keep_q  <= lsb_keep(cnt_ext);
                        end
`endif
                        if (last_in) begin
                            if (v > cnt_ext) begin
                                valid_out_q <= 1'b1;
                                data_out_q  <= first_shift;
                                keep_out_q  <= msb_keep(v - cnt_ext);
                                last_out_q  <= 1'b1;
                            end
                            ready_strip_q <= 1'b1;
                            state_q       <= IDLE;
                        end else begin
                            res_q     <= first_shift;
                            res_cnt_q <= cnt_t'(N) - cnt_ext;
                            state_q   <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (in_fire) begin
                        valid_out_q <= 1'b1;
                        data_out_q  <= merged[2*DATA_WD-1 -: DATA_WD];
                        if (!last_in) begin
                            keep_out_q <= '1;
                            last_out_q <= 1'b0;
                            res_q      <= merged[DATA_WD-1:0];
                        end else if (res_total <= cnt_t'(N)) begin
                            keep_out_q    <= msb_keep(res_total);
                            last_out_q    <= 1'b1;
                            ready_strip_q <= 1'b1;
                            state_q       <= IDLE;
                        end else begin
                            keep_out_q <= '1;
                            last_out_q <= 1'b0;
                            res_q      <= merged[DATA_WD-1:0];
                            res_cnt_q  <= res_total - cnt_t'(N);
                            state_q    <= FLUSH;
                        end
                    end
                end
                FLUSH: begin
                    if (out_free) begin
                        valid_out_q   <= 1'b1;
                        data_out_q    <= res_q;
                        keep_out_q    <= msb_keep(res_cnt_q);
                        last_out_q    <= 1'b1;
                        ready_strip_q <= 1'b1;
                        state_q       <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign valid_out   = valid_out_q;
    assign data_out    = data_out_q;
    assign keep_out    = keep_out_q;
    assign last_out    = last_out_q;
    assign ready_strip = ready_strip_q;
`ifdef STRIP_HDR_OUT_EN
    assign hdr_valid   = hdr_valid_q;
    assign hdr_data    = hdr_data_q;
    assign hdr_keep    = hdr_keep_q;
`endif

endmodule

// File: tb/tb_axi_stream_strip_header.sv
// Directed self-checking bench for axi_stream_strip_header (32-bit bus).
module tb_axi_stream_strip_header;

    logic        clk;
    logic        rst_n;
    logic        valid_in;
    logic        ready_in;
    logic [31:0] data_in;
    logic [3:0]  keep_in;
    logic        last_in;
    logic        valid_out;
    logic        ready_out;
    logic [31:0] data_out;
    logic [3:0]  keep_out;
    logic        last_out;
    logic        valid_strip;
    logic        ready_strip;
    logic [1:0]  byte_strip_cnt;
`ifdef STRIP_HDR_OUT_EN
    logic        hdr_valid;
    logic [31:0] hdr_data;
    logic [3:0]  hdr_keep;
`endif

    int unsigned checks = 0;
    int unsigned errors = 0;

    logic [36:0] got_q[$];
    logic [36:0] exp_q[$];

    axi_stream_strip_header #(
        .DATA_WD(32)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .valid_in       (valid_in),
        .ready_in       (ready_in),
        .data_in        (data_in),
        .keep_in        (keep_in),
        .last_in        (last_in),
        .valid_out      (valid_out),
        .ready_out      (ready_out),
        .data_out       (data_out),
        .keep_out       (keep_out),
        .last_out       (last_out),
        .valid_strip    (valid_strip),
        .ready_strip    (ready_strip),
        .byte_strip_cnt (byte_strip_cnt)
`ifdef STRIP_HDR_OUT_EN
        ,
        .hdr_valid      (hdr_valid),
        .hdr_data       (hdr_data),
        .hdr_keep       (hdr_keep)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Capture every beat that will transfer on the following rising edge.
    always @(negedge clk) begin
        if (rst_n && valid_out && ready_out)
            got_q.push_back({last_out, keep_out, data_out});
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [36:0] mk(input logic [31:0] d, input logic [3:0] k, input logic l);
        return {l, k, d};
    endfunction

    // All tasks begin and end 1 time unit after a rising edge.
    task automatic send_cfg(input logic [1:0] c);
        int unsigned n;
        n = 0;
        valid_strip    = 1'b1;
        byte_strip_cnt = c;
        @(negedge clk);
        while (!ready_strip && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("cfg_wait", ready_strip, 1);
        @(posedge clk);
        #1 valid_strip = 1'b0;
    endtask

    task automatic send_beat(input logic [31:0] d, input logic [3:0] k, input logic l);
        int unsigned n;
        n = 0;
        valid_in = 1'b1;
        data_in  = d;
        keep_in  = k;
        last_in  = l;
        @(negedge clk);
        while (!ready_in && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("beat_wait", ready_in, 1);
        @(posedge clk);
        #1 valid_in = 1'b0;
    endtask

    task automatic drain();
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic compare_stream(input string tag);
        int unsigned n;
        check({tag, "_count"}, 64'(got_q.size()), 64'(exp_q.size()));
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int unsigned i = 0; i < n; i++)
            check($sformatf("%s[%0d]", tag, i), 64'(got_q[i]), 64'(exp_q[i]));
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        rst_n          = 1'b0;
        valid_in       = 1'b0;
        data_in        = '0;
        keep_in        = '0;
        last_in        = 1'b0;
        ready_out      = 1'b1;
        valid_strip    = 1'b0;
        byte_strip_cnt = '0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_valid_out", valid_out, 0);
        check("rst_data_out", data_out, 0);
        check("rst_keep_out", keep_out, 0);
        check("rst_last_out", last_out, 0);
        check("rst_ready_in", ready_in, 0);
        check("rst_ready_strip", ready_strip, 0);
`ifdef STRIP_HDR_OUT_EN
        check("rst_hdr", {hdr_valid, hdr_keep, hdr_data}, 0);
`endif
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_ready_strip", ready_strip, 1);

        // cnt=1, three beats, last keep 1100 -> flush beat
        send_cfg(2'd1);
        check("cfg_ready_in", ready_in, 1);
        check("cfg_ready_strip_low", ready_strip, 0);
        send_beat(32'h01020304, 4'hF, 1'b0);
        send_beat(32'h05060708, 4'hF, 1'b0);
        send_beat(32'h090A0B0C, 4'hC, 1'b1);
        drain();
        exp_q.push_back(mk(32'h02030405, 4'hF, 1'b0));
        exp_q.push_back(mk(32'h06070809, 4'hF, 1'b0));
        exp_q.push_back(mk(32'h0A000000, 4'h8, 1'b1));
        compare_stream("cnt1");

        // cnt=0 passes data through one beat later
        send_cfg(2'd0);
        send_beat(32'h01020304, 4'hF, 1'b0);
        send_beat(32'h05060708, 4'hF, 1'b0);
        send_beat(32'h090A0B0C, 4'hC, 1'b1);
        drain();
        exp_q.push_back(mk(32'h01020304, 4'hF, 1'b0));
        exp_q.push_back(mk(32'h05060708, 4'hF, 1'b0));
        exp_q.push_back(mk(32'h090A0000, 4'hC, 1'b1));
        compare_stream("cnt0");

        // single beat, one-cycle latency
        send_cfg(2'd1);
        send_beat(32'hAABBCCDD, 4'hF, 1'b1);
        check("single_latency", {valid_out, last_out, keep_out, data_out},
              {1'b1, 1'b1, 4'hE, 32'hBBCCDD00});
        check("single_ready_strip", ready_strip, 1);
        drain();
        exp_q.push_back(mk(32'hBBCCDD00, 4'hE, 1'b1));
        compare_stream("single");

        // cnt=3 on a 3-byte single beat: dropped
        send_cfg(2'd3);
        send_beat(32'h01020304, 4'hE, 1'b1);
        check("drop_valid_out", valid_out, 0);
        check("drop_ready_strip", ready_strip, 1);
`ifdef STRIP_HDR_OUT_EN
        check("drop_hdr", {hdr_valid, hdr_keep, hdr_data}, {1'b1, 4'h7, 32'h00010203});
`endif
        drain();
        compare_stream("drop");

        // cnt=2 with a 3-cycle downstream stall
        send_cfg(2'd2);
        send_beat(32'h01020304, 4'hF, 1'b0);
        send_beat(32'h05060708, 4'hF, 1'b0);
        ready_out = 1'b0;
        fork
            send_beat(32'h090A0B0C, 4'hF, 1'b1);
            begin
                repeat (3) begin
                    @(negedge clk);
                    check("stall_hold", {valid_out, last_out, keep_out, data_out},
                          {1'b1, 1'b0, 4'hF, 32'h03040506});
                    check("stall_ready_in", ready_in, 0);
                end
                @(posedge clk);
                #1 ready_out = 1'b1;
            end
        join
        drain();
        exp_q.push_back(mk(32'h03040506, 4'hF, 1'b0));
        exp_q.push_back(mk(32'h0708090A, 4'hF, 1'b0));
        exp_q.push_back(mk(32'h0B0C0000, 4'hC, 1'b1));
        compare_stream("stall");

        // Reset in the middle of a packet with an output beat pending
        send_cfg(2'd1);
        send_beat(32'h01020304, 4'hF, 1'b0);
        send_beat(32'h05060708, 4'hF, 1'b0);
        ready_out = 1'b0;
        valid_in  = 1'b1;
        data_in   = 32'h090A0B0C;
        keep_in   = 4'hF;
        last_in   = 1'b0;
        @(negedge clk);
        check("midrst_pre_valid", valid_out, 1);
        rst_n = 1'b0;
        #1;
        check("midrst_valid_out", valid_out, 0);
        check("midrst_outputs", {last_out, keep_out, data_out}, 0);
        check("midrst_ready_in", ready_in, 0);
        valid_in = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n     = 1'b1;
        ready_out = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_ready_strip", ready_strip, 1);
        compare_stream("midrst_none");

        send_cfg(2'd0);
        send_beat(32'hA1A2A3A4, 4'hF, 1'b0);
        send_beat(32'hB1B2B3B4, 4'h8, 1'b1);
        drain();
        exp_q.push_back(mk(32'hA1A2A3A4, 4'hF, 1'b0));
        exp_q.push_back(mk(32'hB1000000, 4'h8, 1'b1));
        compare_stream("after_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
